lc3_decode_stage: RTL and testbench
===================================

// Module: lc3_decode_stage
// PURPOSE
//  Receiving end of the decode_in bus. Samples instr_dout/npc_in when enable_decode is high.
//  Decodes the LC3 opcode into execute, writeback and memory control words, and registers them
//  for the execute stage (decode_out side). Sits between fetch and execute in the LC3 pipeline.
//  One-cycle registered latency. Holds its outputs while enable_decode is low.
// PARAMETERS
//  DW          16  instruction/PC width; only 16 is supported
//  RESET_NPC   16'h0000  npc_out value on reset
// PORTS
//  clock          input   1   pipeline clock; all state updates on its rising edge
//  reset          input   1   synchronous, active-high reset
//  enable_decode  input   1   decode_in qualifier; capture and decode when 1
//  instr_dout     input   16  instruction word from fetch/imem
//  npc_in         input   16  PC+1 of instr_dout
//  IR             output  16  registered instruction
//  npc_out        output  16  registered npc_in
//  E_Control      output  6   {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//  W_Control      output  2   00=ALU result, 01=memory data, 10=PC-relative address (LEA)
//  Mem_Control    output  1   1 = indirect access (LDI/STI)
//  decode_valid   output  1   1-cycle pulse: outputs updated this cycle
//  illegal_op     output  1   1-cycle pulse: captured opcode unsupported
// BEHAVIOUR
//  - Reset (sync, highest priority, wins over enable_decode): IR=0, npc_out=RESET_NPC,
//    E_Control=0, W_Control=0, Mem_Control=0, decode_valid=0, illegal_op=0.
//  - Edge with enable_decode=1: IR<=instr_dout, npc_out<=npc_in; controls decoded from instr_dout[15:12].
//    decode_valid<=1 on that same edge. The new values are visible in the following cycle.
//  - Edge with enable_decode=0: IR, npc_out and all controls hold. decode_valid<=0, illegal_op<=0.
//  - Back-to-back enables: a new decode every cycle; no bubbles, no internal buffering.
//  - alu_control: 00=ADD, 01=AND, 10=NOT. pcselect1: 00=none, 01=offset9, 10=offset6, 11=zero.
//    pcselect2: 1=npc base, 0=BaseR base. op2select: 1=SR2, 0=imm5.
//  - Fields unused by an opcode are driven 0; there are no don't-cares on the outputs.
//  - Decode table (E_Control / W_Control / Mem_Control):
//    ADD 0001: 00_00_0_~IR5 / 00 / 0      AND 0101: 01_00_0_~IR5 / 00 / 0
//    NOT 1001: 10_00_0_0 / 00 / 0         BR  0000: 00_01_1_0 / 00 / 0
//    JMP 1100: 00_11_0_0 / 00 / 0         LD  0010: 00_01_1_0 / 01 / 0
//    LDR 0110: 00_10_0_0 / 01 / 0         LDI 1010: 00_01_1_0 / 01 / 1
//    LEA 1110: 00_01_1_0 / 10 / 0         ST  0011: 00_01_1_0 / 00 / 0
//    STR 0111: 00_10_0_0 / 00 / 0         STI 1011: 00_01_1_0 / 00 / 1
//  - Unsupported opcodes (0100 JSR, 1000 RTI, 1101 reserved, 1111 TRAP):
//    IR and npc_out are still captured, E/W/Mem_Control are set to 0, and illegal_op<=1 with decode_valid.
//  - ~IR5 in the table is taken from instr_dout[5] at capture time.
//  - npc_out is a pure pass-through; no arithmetic is performed. No wrap handling is needed.
//  - Reset asserted mid-stream: the instruction presented on that edge is discarded, and the
//    first decode after reset is the first enable_decode=1 edge with reset=0.
// TESTING
//  - Reset with enable_decode=1 and instr 0x1283 -> all outputs at reset values; decode_valid=0.
//  - ADD reg 0x1283, npc 0x3001 -> IR=0x1283, npc_out=0x3001, E=6'b000001, W=00, Mem=0, valid pulse.
//  - ADD imm 0x12A5 then AND reg 0x5283, back-to-back -> E=6'b000000 then 6'b010001, valid high 2 cycles.
//  - LDI 0xA005 -> E=6'b000110, W=01, Mem=1. LDR 0x6042 -> E=6'b001000, W=01, Mem=0.
//  - JMP 0xC0C0 -> E=6'b001100, W=00. LEA 0xE1FF -> E=6'b000110, W=10.
//  - TRAP 0xF025, npc 0x3010 -> IR=0xF025, npc_out=0x3010, E=0, W=0, Mem=0, illegal_op pulses 1 cycle.
//  - Enable low for 5 cycles with instr_dout toggling -> all outputs hold; valid and illegal stay 0.

Source files
------------

// File: rtl/lc3_decode_stage.sv
// lc3_decode_stage: decode stage of the LC3 pipeline.
// Captures the fetched instruction and its next-PC, decodes the opcode into
// execute, writeback and memory control words, and presents them registered
// to the execute stage one cycle later. Outputs hold while enable_decode is low.
module lc3_decode_stage #(
  parameter int unsigned      DW        = 16,
  parameter logic [DW-1:0]    RESET_NPC = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_decode,
  input  logic [DW-1:0] instr_dout,
  input  logic [DW-1:0] npc_in,
  output logic [DW-1:0] IR,
  output logic [DW-1:0] npc_out,
  output logic [5:0]    E_Control,
  output logic [1:0]    W_Control,
  output logic          Mem_Control,
  output logic          decode_valid,
  output logic          illegal_op
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [3:0]    opcode;

  logic [1:0]    alu_dec;
  logic [1:0]    pcs1_dec;
  logic          pcs2_dec;
  logic          op2_dec;
  logic [1:0]    wb_dec;
  logic          mem_dec;
  logic          illegal_dec;

  logic [DW-1:0] ir_d, ir_q;
  logic [DW-1:0] npc_d, npc_q;
  logic [5:0]    e_ctrl_d, e_ctrl_q;
  logic [1:0]    w_ctrl_d, w_ctrl_q;
  logic          mem_ctrl_d, mem_ctrl_q;
  logic          valid_d, valid_q;
  logic          illegal_d, illegal_q;

  assign opcode = instr_dout[DW-1 -: 4];

  // Decode the incoming opcode into individual control fields; anything unused stays 0.
  always_comb begin
    alu_dec     = 2'b00;
    pcs1_dec    = 2'b00;
    pcs2_dec    = 1'b0;
    op2_dec     = 1'b0;
    wb_dec      = 2'b00;
    mem_dec     = 1'b0;
    illegal_dec = 1'b0;
    case (opcode)
      OP_ADD: begin
        op2_dec = ~instr_dout[5];
      end
      OP_AND: begin
        alu_dec = 2'b01;
        op2_dec = ~instr_dout[5];
      end
      OP_NOT: begin
        alu_dec = 2'b10;
      end
      OP_BR, OP_ST: begin
        pcs1_dec = 2'b01;
        pcs2_dec = 1'b1;
      end
      OP_JMP: begin
        pcs1_dec = 2'b11;
      end
      OP_LD: begin
        pcs1_dec = 2'b01;
        pcs2_dec = 1'b1;
        wb_dec   = 2'b01;
      end
      OP_LDR: begin
        pcs1_dec = 2'b10;
        wb_dec   = 2'b01;
      end
      OP_LDI: begin
        pcs1_dec = 2'b01;
        pcs2_dec = 1'b1;
        wb_dec   = 2'b01;
        mem_dec  = 1'b1;
      end
      OP_LEA: begin
        pcs1_dec = 2'b01;
        pcs2_dec = 1'b1;
        wb_dec   = 2'b10;
      end
      OP_STR: begin
        pcs1_dec = 2'b10;
      end
      OP_STI: begin
        pcs1_dec = 2'b01;
        pcs2_dec = 1'b1;
        mem_dec  = 1'b1;
      end
      default: begin
        illegal_dec = 1'b1;
      end
    endcase
  end

  // Next-state: capture and decode on enable, otherwise hold outputs and drop the pulses.
  always_comb begin
    ir_d       = ir_q;
    npc_d      = npc_q;
    e_ctrl_d   = e_ctrl_q;
    w_ctrl_d   = w_ctrl_q;
    mem_ctrl_d = mem_ctrl_q;
    valid_d    = 1'b0;
    illegal_d  = 1'b0;
    if (enable_decode) begin
      ir_d       = instr_dout;
      npc_d      = npc_in;
      e_ctrl_d   = {alu_dec, pcs1_dec, pcs2_dec, op2_dec};
      w_ctrl_d   = wb_dec;
      mem_ctrl_d = mem_dec;
      valid_d    = 1'b1;
      illegal_d  = illegal_dec;
    end
  end

  // Pipeline register with synchronous reset taking priority over any capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q       <= '0;
      npc_q      <= RESET_NPC;
      e_ctrl_q   <= 6'b000000;
      w_ctrl_q   <= 2'b00;
      mem_ctrl_q <= 1'b0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      npc_q      <= npc_d;
      e_ctrl_q   <= e_ctrl_d;
      w_ctrl_q   <= w_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign IR           = ir_q;
  assign npc_out      = npc_q;
  assign E_Control    = e_ctrl_q;
  assign W_Control    = w_ctrl_q;
  assign Mem_Control  = mem_ctrl_q;
  assign decode_valid = valid_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// tb_lc3_decode_stage: directed and randomized checks of the decode stage
// against a table-driven model of the LC3 opcode semantics.
module tb_lc3_decode_stage;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] instr_dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        decode_valid;
  logic        illegal_op;

  lc3_decode_stage #(.DW(16), .RESET_NPC(16'h0000)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .instr_dout    (instr_dout),
    .npc_in        (npc_in),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control),
    .decode_valid  (decode_valid),
    .illegal_op    (illegal_op)
  );

  // Per-opcode semantics: which ALU op, which PC offset/base, whether
  // operand 2 follows IR[5], what gets written back and if memory is indirect.
  typedef struct {
    logic [1:0] alu;
    logic [1:0] pcOffset;
    logic       npcBase;
    logic       op2FromBit5;
    logic [1:0] writeback;
    logic       indirect;
    logic       legal;
  } opInfo_t;

  opInfo_t opTable [16];

  int testCount = 0;
  int failCount = 0;

  logic [15:0] expIr;
  logic [15:0] expNpc;
  logic [5:0]  expE;
  logic [1:0]  expW;
  logic        expMem;
  logic        expValid;
  logic        expIllegal;

  // Free-running pipeline clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".IR"},      {16'h0, IR},          {16'h0, expIr});
    checkOutput({tag, ".npc"},     {16'h0, npc_out},     {16'h0, expNpc});
    checkOutput({tag, ".E"},       {26'h0, E_Control},   {26'h0, expE});
    checkOutput({tag, ".W"},       {30'h0, W_Control},   {30'h0, expW});
    checkOutput({tag, ".Mem"},     {31'h0, Mem_Control}, {31'h0, expMem});
    checkOutput({tag, ".valid"},   {31'h0, decode_valid}, {31'h0, expValid});
    checkOutput({tag, ".illegal"}, {31'h0, illegal_op},  {31'h0, expIllegal});
  endtask

  // Advance the reference model by one clock edge with the given inputs.
  task automatic stepModel(input logic rst, input logic en, input logic [15:0] instr, input logic [15:0] npc);
    opInfo_t info;
    if (rst) begin
      expIr = 16'h0; expNpc = 16'h0; expE = 6'h0; expW = 2'b00;
      expMem = 1'b0; expValid = 1'b0; expIllegal = 1'b0;
    end else if (en) begin
      info     = opTable[instr[15:12]];
      expIr    = instr;
      expNpc   = npc;
      expValid = 1'b1;
      if (info.legal) begin
        expE       = {info.alu, info.pcOffset, info.npcBase, info.op2FromBit5 ? ~instr[5] : 1'b0};
        expW       = info.writeback;
        expMem     = info.indirect;
        expIllegal = 1'b0;
      end else begin
        expE = 6'h0; expW = 2'b00; expMem = 1'b0; expIllegal = 1'b1;
      end
    end else begin
      expValid   = 1'b0;
      expIllegal = 1'b0;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rst, input logic en,
                               input logic [15:0] instr, input logic [15:0] npc);
    @(negedge clock);
    reset         = rst;
    enable_decode = en;
    instr_dout    = instr;
    npc_in        = npc;
    @(posedge clock);
    #1;
    stepModel(rst, en, instr, npc);
    checkAll(tag);
  endtask

  task automatic buildTable();
    for (int i = 0; i < 16; i++) opTable[i] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    opTable[4'b0001] = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1}; // ADD
    opTable[4'b0101] = '{2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1}; // AND
    opTable[4'b1001] = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1}; // NOT
    opTable[4'b0000] = '{2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1}; // BR
    opTable[4'b1100] = '{2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1}; // JMP
    opTable[4'b0010] = '{2'b00, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1}; // LD
    opTable[4'b0110] = '{2'b00, 2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1}; // LDR
    opTable[4'b1010] = '{2'b00, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1}; // LDI
    opTable[4'b1110] = '{2'b00, 2'b01, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1}; // LEA
    opTable[4'b0011] = '{2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1}; // ST
    opTable[4'b0111] = '{2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1}; // STR
    opTable[4'b1011] = '{2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1}; // STI
  endtask

  // Directed scenarios followed by a randomized stream with occasional resets.
  initial begin
    logic        rRst;
    logic        rEn;
    logic [15:0] rInstr;
    logic [15:0] rNpc;

    buildTable();
    reset = 1'b1; enable_decode = 1'b0; instr_dout = 16'h0; npc_in = 16'h0;

    applyStimulus("reset_with_enable", 1'b1, 1'b1, 16'h1283, 16'h3001);
    applyStimulus("reset_hold", 1'b1, 1'b0, 16'h0000, 16'h0000);

    applyStimulus("add_reg", 1'b0, 1'b1, 16'h1283, 16'h3001);
    checkOutput("add_reg.E_lit", {26'h0, E_Control}, 32'h01);

    applyStimulus("add_imm", 1'b0, 1'b1, 16'h12A5, 16'h3002);
    checkOutput("add_imm.E_lit", {26'h0, E_Control}, 32'h00);
    applyStimulus("and_reg", 1'b0, 1'b1, 16'h5283, 16'h3003);
    checkOutput("and_reg.E_lit", {26'h0, E_Control}, 32'h11);

    applyStimulus("ldi", 1'b0, 1'b1, 16'hA005, 16'h3004);
    checkOutput("ldi.E_lit", {26'h0, E_Control}, 32'h06);
    checkOutput("ldi.Mem_lit", {31'h0, Mem_Control}, 32'h1);
    applyStimulus("ldr", 1'b0, 1'b1, 16'h6042, 16'h3005);
    checkOutput("ldr.E_lit", {26'h0, E_Control}, 32'h08);
    applyStimulus("jmp", 1'b0, 1'b1, 16'hC0C0, 16'h3006);
    checkOutput("jmp.E_lit", {26'h0, E_Control}, 32'h0C);
    applyStimulus("lea", 1'b0, 1'b1, 16'hE1FF, 16'h3007);
    checkOutput("lea.W_lit", {30'h0, W_Control}, 32'h2);

    applyStimulus("trap", 1'b0, 1'b1, 16'hF025, 16'h3010);
    checkOutput("trap.illegal_lit", {31'h0, illegal_op}, 32'h1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus("hold", 1'b0, 1'b0, (i % 2 == 0) ? 16'hFFFF : 16'h1234, 16'hBEEF);
    end
    checkOutput("hold.IR_lit", {16'h0, IR}, 32'hF025);

    applyStimulus("reset_mid", 1'b1, 1'b1, 16'h5283, 16'h4000);
    applyStimulus("after_reset", 1'b0, 1'b1, 16'h2E10, 16'h4001);

    for (int i = 0; i < 400; i++) begin
      rRst   = ($urandom_range(0, 19) == 0);
      rEn    = ($urandom_range(0, 3) != 0);
      rInstr = 16'($urandom);
      rNpc   = 16'($urandom);
      applyStimulus("random", rRst, rEn, rInstr, rNpc);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
